// File: rtl/alarm_controller.sv
// Anti-theft alarm sequencer: tracks ignition/doors, selects and starts the shared
// countdown interval, and drives the siren and the status LED.
module alarm_controller #(
   parameter int unsigned BLINK_DIV = 10,
   parameter int unsigned CW        = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ignition,
   input  logic       door_driver,
   input  logic       door_pass,
   input  logic       reprogram,
   input  logic       expired,
   output logic [1:0] interval,
   output logic       start_timer,
   output logic       siren_enable,
   output logic       status_indicator,
   output logic [2:0] state_out
);

   localparam int unsigned GW         = 2;
   localparam logic [GW-1:0] GUARD_DONE = GW'(2);
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

   localparam logic [1:0] IV_ARM_DELAY  = 2'd0;
   localparam logic [1:0] IV_DRIVER     = 2'd1;
   localparam logic [1:0] IV_PASSENGER  = 2'd2;
   localparam logic [1:0] IV_ALARM_ON   = 2'd3;

   typedef enum logic [2:0] {
      ARMED             = 3'd0,
      TRIGGERED         = 3'd1,
      SOUND_ALARM       = 3'd2,
      ALARM_HOLD        = 3'd3,
      DISARMED          = 3'd4,
      WAIT_DRIVER_OUT   = 3'd5,
      WAIT_DOORS_CLOSED = 3'd6,
      ARM_DELAY         = 3'd7
   } state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] guard_q, guard_d;
   logic [CW-1:0] blink_q, blink_d;
   logic          led_q, led_d;
   logic [1:0]    iv_q, iv_d;
   logic          start_q, start_d;
   logic          siren_q, siren_d;
   logic          any_door;
   logic          exp_ok;
   logic          changed;

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ARMED;
         guard_q <= '0;
         blink_q <= '0;
         led_q   <= 1'b0;
         iv_q    <= IV_ARM_DELAY;
         start_q <= 1'b0;
         siren_q <= 1'b0;
      end else begin
         state_q <= state_d;
         guard_q <= guard_d;
         blink_q <= blink_d;
         led_q   <= led_d;
         iv_q    <= iv_d;
         start_q <= start_d;
         siren_q <= siren_d;
      end
   end

   // Next state, start pulse and next registered outputs
   always_comb begin
      state_d  = state_q;
      iv_d     = iv_q;
      start_d  = 1'b0;
      siren_d  = 1'b0;
      led_d    = 1'b0;
      blink_d  = '0;
      guard_d  = guard_q;
      changed  = 1'b0;
      any_door = door_driver | door_pass;
      // expired is stale during the start and load cycles of a timed state
      exp_ok   = expired && (guard_q == GUARD_DONE);

      if (reprogram) begin
         state_d = ARMED;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (ignition) begin
                  state_d = DISARMED;
               end else if (door_driver) begin
                  state_d = TRIGGERED;
                  iv_d    = IV_DRIVER;
                  start_d = 1'b1;
               end else if (door_pass) begin
                  state_d = TRIGGERED;
                  iv_d    = IV_PASSENGER;
                  start_d = 1'b1;
               end
            end
            TRIGGERED: begin
               if (ignition)    state_d = DISARMED;
               else if (exp_ok) state_d = SOUND_ALARM;
            end
            SOUND_ALARM: begin
               if (ignition) begin
                  state_d = DISARMED;
               end else if (!any_door) begin
                  state_d = ALARM_HOLD;
                  iv_d    = IV_ALARM_ON;
                  start_d = 1'b1;
               end
            end
            ALARM_HOLD: begin
               if (ignition)      state_d = DISARMED;
               else if (any_door) state_d = SOUND_ALARM;
               else if (exp_ok)   state_d = ARMED;
            end
            DISARMED: begin
               if (!ignition) state_d = WAIT_DRIVER_OUT;
            end
            WAIT_DRIVER_OUT: begin
               if (ignition)         state_d = DISARMED;
               else if (door_driver) state_d = WAIT_DOORS_CLOSED;
            end
            WAIT_DOORS_CLOSED: begin
               if (ignition) begin
                  state_d = DISARMED;
               end else if (!any_door) begin
                  state_d = ARM_DELAY;
                  iv_d    = IV_ARM_DELAY;
                  start_d = 1'b1;
               end
            end
            ARM_DELAY: begin
               if (ignition)      state_d = DISARMED;
               else if (any_door) state_d = WAIT_DOORS_CLOSED;
               else if (exp_ok)   state_d = ARMED;
            end
            default: state_d = ARMED;
         endcase
      end

      // A reprogram counts as a fresh entry even when already ARMED
      changed = reprogram || (state_d != state_q);

      if (changed)                    guard_d = '0;
      else if (guard_q != GUARD_DONE) guard_d = guard_q + GW'(1);

      siren_d = (state_d == SOUND_ALARM) || (state_d == ALARM_HOLD);

      unique case (state_d)
         ARMED: begin
            if (changed) begin
               blink_d = '0;
               led_d   = 1'b0;
            end else if (blink_q == BLINK_LAST) begin
               blink_d = '0;
               led_d   = ~led_q;
            end else begin
               blink_d = blink_q + CW'(1);
               led_d   = led_q;
            end
         end
         TRIGGERED, SOUND_ALARM, ALARM_HOLD: led_d = 1'b1;
         default:                            led_d = 1'b0;
      endcase
   end

   assign interval         = iv_q;
   assign start_timer      = start_q;
   assign siren_enable     = siren_q;
   assign status_indicator = led_q;
   assign state_out        = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed vector table, hand-written
// corner sequences, and randomized stimulus against a behavioural model.
module tb_alarm_controller;

   localparam int unsigned BLINK_DIV = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ignition = 1'b0, door_driver = 1'b0, door_pass = 1'b0;
   logic       reprogram = 1'b0, expired = 1'b0;
   logic [1:0] interval;
   logic       start_timer, siren_enable, status_indicator;
   logic [2:0] state_out;

   int total = 0;
   int bad   = 0;

   alarm_controller #(.BLINK_DIV(BLINK_DIV), .CW(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .ignition         (ignition),
      .door_driver      (door_driver),
      .door_pass        (door_pass),
      .reprogram        (reprogram),
      .expired          (expired),
      .interval         (interval),
      .start_timer      (start_timer),
      .siren_enable     (siren_enable),
      .status_indicator (status_indicator),
      .state_out        (state_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       ign, dd, dp, rp, ex;
      logic [2:0] st;
      logic       start;
      logic [1:0] iv;
      logic       siren, led;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int a, b, c, d, e, st, s, iv, sr, l);
      vec_t v;
      v.ign = 1'(a); v.dd = 1'(b); v.dp = 1'(c); v.rp = 1'(d); v.ex = 1'(e);
      v.st = 3'(st); v.start = 1'(s); v.iv = 2'(iv); v.siren = 1'(sr); v.led = 1'(l);
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic a, b, c, d, e);
      ignition = a; door_driver = b; door_pass = c; reprogram = d; expired = e;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] st, input logic s,
                            input logic [1:0] iv, input logic sr, input logic l);
      check({tag, " state"}, 8'(state_out), 8'(st));
      check({tag, " start"}, 8'(start_timer), 8'(s));
      check({tag, " interval"}, 8'(interval), 8'(iv));
      check({tag, " siren"}, 8'(siren_enable), 8'(sr));
      check({tag, " led"}, 8'(status_indicator), 8'(l));
   endtask

   // Behavioural model: state code, cycles since entry, and LED from elapsed ARMED time
   int   m_state, m_age, m_armed_n, m_iv;
   logic e_start, e_led, e_siren;

   task automatic model_reset();
      m_state = 0; m_age = 0; m_armed_n = 0; m_iv = 0;
      e_start = 1'b0; e_led = 1'b0; e_siren = 1'b0;
   endtask

   task automatic model_step(input logic ign, dd, dp, rp, ex);
      int   nxt;
      logic g, entered, door;
      nxt = m_state;
      g = ex && (m_age >= 2);
      door = dd || dp;
      e_start = 1'b0;
      if (rp) nxt = 0;
      else begin
         case (m_state)
            0: if (ign) nxt = 4;
               else if (dd) begin nxt = 1; m_iv = 1; e_start = 1'b1; end
               else if (dp) begin nxt = 1; m_iv = 2; e_start = 1'b1; end
            1: if (ign) nxt = 4; else if (g) nxt = 2;
            2: if (ign) nxt = 4;
               else if (!door) begin nxt = 3; m_iv = 3; e_start = 1'b1; end
            3: if (ign) nxt = 4; else if (door) nxt = 2; else if (g) nxt = 0;
            4: if (!ign) nxt = 5;
            5: if (ign) nxt = 4; else if (dd) nxt = 6;
            6: if (ign) nxt = 4;
               else if (!door) begin nxt = 7; m_iv = 0; e_start = 1'b1; end
            7: if (ign) nxt = 4; else if (door) nxt = 6; else if (g) nxt = 0;
            default: nxt = 0;
         endcase
      end
      entered   = rp || (nxt != m_state);
      m_age     = entered ? 0 : m_age + 1;
      m_armed_n = entered ? 0 : m_armed_n + 1;
      m_state   = nxt;
      e_siren   = (nxt == 2) || (nxt == 3);
      if (nxt == 0) e_led = 1'(((m_armed_n / int'(BLINK_DIV)) % 2));
      else          e_led = (nxt >= 1) && (nxt <= 3);
   endtask

   initial begin
      // ign dd dp rp ex | state start iv siren led
      tbl.push_back(mk(0,0,1,0,1, 1,1,2,0,1));
      tbl.push_back(mk(0,0,0,0,1, 1,0,2,0,1));
      tbl.push_back(mk(0,0,0,0,1, 1,0,2,0,1));
      tbl.push_back(mk(0,0,0,0,1, 2,0,2,1,1));
      tbl.push_back(mk(0,0,0,0,1, 3,1,3,1,1));
      tbl.push_back(mk(0,1,0,0,1, 2,0,3,1,1));
      tbl.push_back(mk(0,0,0,0,1, 3,1,3,1,1));
      tbl.push_back(mk(0,0,0,0,1, 3,0,3,1,1));
      tbl.push_back(mk(0,0,0,0,1, 3,0,3,1,1));
      tbl.push_back(mk(0,0,0,0,1, 0,0,3,0,0));
      tbl.push_back(mk(1,0,0,0,1, 4,0,3,0,0));
      tbl.push_back(mk(1,0,0,0,1, 4,0,3,0,0));
      tbl.push_back(mk(0,0,0,0,1, 5,0,3,0,0));
      tbl.push_back(mk(0,1,0,0,1, 6,0,3,0,0));
      tbl.push_back(mk(0,1,0,0,1, 6,0,3,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,1,0,0,0));
      tbl.push_back(mk(0,0,1,0,1, 6,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,1, 6,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 7,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,1, 1,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1, 1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,1, 1,0,1,0,1));
      tbl.push_back(mk(1,0,0,0,1, 4,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,0, 5,0,1,0,0));
      tbl.push_back(mk(0,1,0,0,0, 6,0,1,0,0));
      tbl.push_back(mk(0,0,0,0,0, 7,1,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 7,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0));
      tbl.push_back(mk(1,1,0,0,0, 4,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0, 5,0,0,0,0));
      tbl.push_back(mk(0,1,0,1,0, 0,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0, 1,1,2,0,1));
      tbl.push_back(mk(0,0,0,0,0, 1,0,2,0,1));
      tbl.push_back(mk(0,0,0,0,0, 1,0,2,0,1));
      tbl.push_back(mk(0,0,0,0,1, 2,0,2,1,1));
      tbl.push_back(mk(0,0,0,0,0, 3,1,3,1,1));
      tbl.push_back(mk(0,0,0,0,0, 3,0,3,1,1));
      tbl.push_back(mk(0,0,0,0,0, 3,0,3,1,1));
      tbl.push_back(mk(0,1,0,0,1, 2,0,3,1,1));
      tbl.push_back(mk(0,0,0,0,0, 3,1,3,1,1));
      tbl.push_back(mk(0,0,0,1,0, 0,0,3,0,0));
      tbl.push_back(mk(0,0,0,0,0, 0,0,3,0,0));

      // Reset values while held in reset
      tick();
      tick();
      check_all("reset", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

      // LED blink in ARMED after release: toggles at clocks 10, 20, 30
      reset = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         check($sformatf("blink%0d led", k), 8'(status_indicator), 8'((k / 10) % 2));
         check($sformatf("blink%0d start", k), 8'(start_timer), 8'd0);
         check($sformatf("blink%0d state", k), 8'(state_out), 8'd0);
      end

      // Directed vector table
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         set_in(tbl[i].ign, tbl[i].dd, tbl[i].dp, tbl[i].rp, tbl[i].ex);
         tick();
         check_all($sformatf("row%0d", i), tbl[i].st, tbl[i].start, tbl[i].iv,
                   tbl[i].siren, tbl[i].led);
      end

      // Asynchronous reset in SOUND_ALARM, between clock edges
      do_reset();
      set_in(0, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) tick();
      check_all("pre_async", 3'd2, 1'b0, 2'd2, 1'b1, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check_all("async_rst", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      #2;
      set_in(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      check_all("post_release", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

      // Randomized stimulus against the behavioural model
      do_reset();
      model_reset();
      for (int n = 0; n < 4000; n++) begin
         logic ig, dd, dp, rp, ex;
         ig = ignition;
         if ($urandom_range(0, 14) == 0) ig = ~ig;
         dd = door_driver;
         if ($urandom_range(0, 3) == 0) dd = ~dd;
         dp = door_pass;
         if ($urandom_range(0, 3) == 0) dp = ~dp;
         rp = ($urandom_range(0, 39) == 0);
         ex = ($urandom_range(0, 9) < 6);
         set_in(ig, dd, dp, rp, ex);
         tick();
         model_step(ig, dd, dp, rp, ex);
         check_all($sformatf("rnd%0d", n), 3'(m_state), e_start, 2'(m_iv), e_siren, e_led);
         if ($urandom_range(0, 299) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_all($sformatf("rnd_rst%0d", n), 3'(m_state), e_start, 2'(m_iv),
                      e_siren, e_led);
            reset = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
